// File: rtl/hdmi_timing_pkg.sv
// 1080p60 CEA-861 raster constants and the controller state type shared by
// the video timing generator.
package hdmi_timing_pkg;

  localparam int H_ACTIVE     = 1920;
  localparam int H_FRONT      = 88;
  localparam int H_SYNC       = 44;
  localparam int H_BACK       = 148;
  localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE     = 1080;
  localparam int V_FRONT      = 4;
  localparam int V_SYNC       = 5;
  localparam int V_BACK       = 36;
  localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam bit HS_POL       = 1'b1;
  localparam bit VS_POL       = 1'b1;
  localparam int LOCK_HOLDOFF = 1024;
  localparam int CW           = 12;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RUN       = 2'd2
  } vtg_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a slow level signal crossing into the clk domain.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a stable PLL lock, then sweeps h/v and
// decodes registered hsync/vsync/de/x/y plus line and frame start pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | synchronized lock low; raster idle, outputs at idle levels
//   HOLDOFF   | lock high, counting LOCK_HOLDOFF continuous locked clocks
//   RUN       | raster counters sweeping, outputs decoded from (h, v)
module video_timing_gen import hdmi_timing_pkg::*; #(
  parameter int H_ACTIVE     = hdmi_timing_pkg::H_ACTIVE,
  parameter int H_FRONT      = hdmi_timing_pkg::H_FRONT,
  parameter int H_SYNC       = hdmi_timing_pkg::H_SYNC,
  parameter int H_BACK       = hdmi_timing_pkg::H_BACK,
  parameter int V_ACTIVE     = hdmi_timing_pkg::V_ACTIVE,
  parameter int V_FRONT      = hdmi_timing_pkg::V_FRONT,
  parameter int V_SYNC       = hdmi_timing_pkg::V_SYNC,
  parameter int V_BACK       = hdmi_timing_pkg::V_BACK,
  parameter bit HS_POL       = hdmi_timing_pkg::HS_POL,
  parameter bit VS_POL       = hdmi_timing_pkg::VS_POL,
  parameter int LOCK_HOLDOFF = hdmi_timing_pkg::LOCK_HOLDOFF,
  parameter int CW           = hdmi_timing_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  output logic          running,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW    = (LOCK_HOLDOFF > 1) ? $clog2(LOCK_HOLDOFF) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(LOCK_HOLDOFF - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  if (H_TOT >= (1 << CW) || V_TOT >= (1 << CW)) begin : g_cw_too_small
    $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  vtg_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          lock_s;
  logic          h_act;
  logic          v_act;
  logic          hs_act;
  logic          vs_act;

  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // vsync spans from the hsync leading edge of line VS_START up to the same
  // pixel of line VS_END, so both sync edges line up.
  always_comb begin
    h_act  = h_cnt < H_ACT_C;
    v_act  = v_cnt < V_ACT_C;
    hs_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act = ((v_cnt == VS_START) && (h_cnt >= HS_START)) ||
             ((v_cnt >  VS_START) && (v_cnt <  VS_END))   ||
             ((v_cnt == VS_END)   && (h_cnt <  HS_START));
  end

  assign running = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (lock_s) begin
            state    <= HOLDOFF;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLDOFF: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (hold_cnt == '0) begin
            state <= RUN;
            h_cnt <= '0;
            v_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            h_cnt <= '0;
            v_cnt <= '0;
          end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
          end else begin
            h_cnt <= h_cnt + CNT_ONE;
          end
        end
        default: state <= WAIT_LOCK;
      endcase

      // Outputs drop to idle on the same edge that leaves RUN.
      if (state == RUN && lock_s) begin
        de          <= h_act && v_act;
        x           <= (h_act && v_act) ? h_cnt : '0;
        y           <= (h_act && v_act) ? v_cnt : '0;
        hsync       <= hs_act ? HS_POL : ~HS_POL;
        vsync       <= vs_act ? VS_POL : ~VS_POL;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end else begin
        de          <= 1'b0;
        x           <= '0;
        y           <= '0;
        hsync       <= ~HS_POL;
        vsync       <= ~VS_POL;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster: a position-based reference
// model checked every cycle, plus directed lock/reset scenarios.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 4, HSW = 3, HB = 5;
  localparam int VA = 8,  VF = 2, VSW = 2, VB = 3;
  localparam int L  = 16;
  localparam int CW = 12;
  localparam int HT = HA + HF + HSW + HB;   // 28
  localparam int VT = VA + VF + VSW + VB;   // 15
  localparam int FT = HT * VT;              // 420
  localparam int VS0 = (VA + VF) * HT + HA + HF;
  localparam int VS1 = (VA + VF + VSW) * HT + HA + HF;
  localparam int LAT = L + 4;
  // Both sync polarities are active-high here, so the idle vector is all zeros.
  localparam logic [29:0] RST_VEC = 30'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b1;
  logic          running, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;

  int total = 0;
  int bad   = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_HOLDOFF(L), .CW(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .running     (running),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] decode(input int p);
    int   h, v;
    logic d, hs, vs;
    h  = p % HT;
    v  = p / HT;
    d  = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HSW);
    vs = (p >= VS0) && (p < VS1);
    return {1'b1, hs, vs, d, (h == 0), (p == 0),
            d ? 12'(h) : 12'h0, d ? 12'(v) : 12'h0};
  endfunction

  // Reference: running needs L+1 consecutive synchronized-lock samples;
  // raster position counts clocks since RUN began.
  bit          sy1 = 1'b0, sy2 = 1'b0, m_run = 1'b0, run_prev;
  int          streak = 0, m_pos = 0, pos_prev;
  logic [29:0] exp_vec = RST_VEC;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1 = 1'b0; sy2 = 1'b0; streak = 0; m_run = 1'b0; m_pos = 0;
      exp_vec = RST_VEC;
    end else begin
      run_prev = m_run;
      pos_prev = m_pos;
      if (sy2) begin
        if (streak < 1000000) streak++;
      end else begin
        streak = 0;
      end
      m_run = (streak >= L + 1);
      m_pos = (m_run && run_prev) ? (pos_prev + 1) % FT : 0;
      if (run_prev && m_run) exp_vec = decode(pos_prev);
      else                   exp_vec = {m_run, 29'h0};
      sy2 = sy1;
      sy1 = pll_locked;
    end
  end

  logic [29:0] act_vec;
  always @(negedge clk) begin
    act_vec = {running, hsync, vsync, de, line_start, frame_start, x, y};
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      if (bad <= 20)
        $display("FAIL model_cycle t=%0t got=%h expected=%h (run,hs,vs,de,ls,fs,x,y)",
                 $time, act_vec, exp_vec);
    end
  end

  // Edge/width/period measurements on the observed outputs.
  int cyc = 0;
  int hs_rise = -1, hs_period = 0, hs_width = 0;
  int vs_rise = -1, vs_period = 0, vs_width = 0;
  int de_rise = 0, de_width = 0, de_line_cnt = 0, de_lines = 0;
  int x_max = 0, y_max = 0;
  bit vs_with_hs = 1'b0;
  logic hs_p = 1'b0, vs_p = 1'b0, de_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (hsync && !hs_p) begin
      if (hs_rise >= 0) hs_period = cyc - hs_rise;
      hs_rise = cyc;
    end
    if (!hsync && hs_p) hs_width = cyc - hs_rise;
    if (vsync && !vs_p) begin
      if (vs_rise >= 0) vs_period = cyc - vs_rise;
      vs_rise     = cyc;
      vs_with_hs  = hsync && !hs_p;
      de_lines    = de_line_cnt;
      de_line_cnt = 0;
    end
    if (!vsync && vs_p) vs_width = cyc - vs_rise;
    if (de && !de_p) begin
      de_rise = cyc;
      de_line_cnt++;
    end
    if (!de && de_p) de_width = cyc - de_rise;
    if (de) begin
      if (int'(x) > x_max) x_max = int'(x);
      if (int'(y) > y_max) y_max = int'(y);
    end
    hs_p = hsync; vs_p = vsync; de_p = de;
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic wait_de(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!de && n < 400);
  endtask

  task automatic wait_pos(input int px, input int py);
    int k;
    k = 0;
    while (!(de && int'(x) == px && int'(y) == py) && k < 2 * FT) begin
      @(negedge clk);
      k++;
    end
    check("find_position", (de && int'(x) == px && int'(y) == py), 1);
  endtask

  int n;
  bit seen;
  int offs [2] = '{8, 15};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {running, hsync, vsync, de, line_start, frame_start, x, y}, RST_VEC);

    // Startup: sync(2) + lock detect(1) + holdoff(L) + output register(1).
    rst_n = 1'b1;
    wait_de(n);
    check("first_de_latency", n, LAT);
    check("first_x", x, 0);
    check("first_y", y, 0);
    check("first_frame_start", frame_start, 1);
    check("first_line_start", line_start, 1);
    check("first_running", running, 1);

    repeat (1000) @(negedge clk);
    check("hsync_width", hs_width, HSW);
    check("hsync_period", hs_period, HT);
    check("de_width", de_width, HA);
    check("x_max", x_max, HA - 1);
    check("y_max", y_max, VA - 1);
    check("vsync_width", vs_width, VSW * HT);
    check("vsync_period", vs_period, FT);
    check("de_lines_per_frame", de_lines, VA);
    check("vsync_on_hsync_edge", vs_with_hs, 1);

    wait_pos(0, 1);
    check("row1_line_start", line_start, 1);
    check("row1_frame_start", frame_start, 0);

    // Lock loss mid-frame, then relock into a fresh frame.
    wait_pos(10, 5);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_outputs_idle", {running, hsync, vsync, de, line_start, frame_start, x, y}, RST_VEC);
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    wait_de(n);
    check("relock_latency", n, LAT);
    check("relock_x", x, 0);
    check("relock_y", y, 0);
    check("relock_frame_start", frame_start, 1);

    // Lock glitches inside HOLDOFF must restart the full holdoff.
    for (int i = 0; i < 2; i++) begin
      pll_locked = 1'b0;
      repeat (6) @(negedge clk);
      pll_locked = 1'b1;
      seen = 1'b0;
      repeat (offs[i]) begin @(negedge clk); seen |= de; end
      pll_locked = 1'b0;
      repeat (10) begin @(negedge clk); seen |= de; end
      pll_locked = 1'b1;
      wait_de(n);
      check("glitch_no_early_de", seen, 0);
      check("glitch_restart_latency", n, LAT);
    end

    // Asynchronous reset mid-line.
    wait_pos(5, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {running, hsync, vsync, de, line_start, frame_start, x, y}, RST_VEC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_de(n);
    check("post_reset_latency", n, LAT);
    check("post_reset_frame_start", frame_start, 1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
